// File: rtl/pipe_skid_stage_pkg.sv
// rtl/pipe_skid_stage_pkg.sv - default payload widths and NOP control value for pipe_skid_stage
package pipe_skid_stage_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int DUP_N_DEF  = 2;

    // An all-zero control word performs no architectural action downstream
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid+payload register with load and clear (clear wins)
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clearing only drops the valid bit; payload holds its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage with flush, NOP bubbles and replicated data
// PIPE_SKID_EN selects the two-entry skid variant with registered in_ready_o.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DUP_N  = DUP_N_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [PC_W-1:0]         in_pc_i,
    input  logic [CTRL_W-1:0]       in_ctrl_i,
    input  logic [DATA_W-1:0]       in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [PC_W-1:0]         out_pc_o,
    output logic [CTRL_W-1:0]       out_ctrl_o,
    output logic [DUP_N*DATA_W-1:0] out_data_o,
    output logic [1:0]              occ_o
);

    localparam int PW = PC_W + CTRL_W;

    logic                 w_main_valid;
    logic [PW-1:0]        w_main_q;
    logic                 w_skid_valid;
    logic [PW+DATA_W-1:0] w_skid_q;
    logic                 w_in_fire;
    logic                 w_main_free;
    logic                 w_main_load;
    logic                 w_main_clear;
    logic [PW-1:0]        w_main_d;
    logic [DATA_W-1:0]    w_data_d;

    assign w_main_free = ~w_main_valid | out_ready_i;
    assign w_in_fire   = in_valid_i & in_ready_o;

    // A waiting skid beat always refills main before any new input is taken
    assign w_main_load  = ~flush_i & (w_skid_valid ? w_main_free : (w_in_fire & w_main_free));
    assign w_main_clear = flush_i | (w_main_valid & out_ready_i & ~w_main_load);
    assign {w_main_d, w_data_d} = w_skid_valid ? w_skid_q : {in_pc_i, in_ctrl_i, in_data_i};

    pipe_entry_reg #(.W(PW)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_q)
    );

`ifdef PIPE_SKID_EN
    logic w_skid_load;
    logic w_skid_clear;

    assign w_skid_load  = ~flush_i & w_in_fire & ~w_main_free;
    assign w_skid_clear = flush_i | (w_skid_valid & w_main_free);

    pipe_entry_reg #(.W(PW + DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  ({in_pc_i, in_ctrl_i, in_data_i}),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_q)
    );

    assign in_ready_o = ~w_skid_valid;
`else
    assign w_skid_valid = 1'b0;
    assign w_skid_q     = '0;
    assign in_ready_o   = ~w_main_valid | out_ready_i;
`endif

    // Separate copies feed the MEM and forwarding paths; keep stops them being merged
    for (genvar k = 0; k < DUP_N; k++) begin : g_dup
        (* keep = "true" *) logic [DATA_W-1:0] r_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data <= '0;
            end else if (w_main_load) begin
                r_data <= w_data_d;
            end
        end

        assign out_data_o[k*DATA_W +: DATA_W] = r_data;
    end

    assign out_valid_o = w_main_valid;
    assign out_pc_o    = w_main_q[PW-1:CTRL_W];
    assign out_ctrl_o  = w_main_valid ? w_main_q[CTRL_W-1:0] : CTRL_W'(CTRL_NOP);
    assign occ_o       = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage (both PIPE_SKID_EN builds)
module tb_pipe_skid_stage;

    localparam int PC_W   = 32;
    localparam int CTRL_W = 16;
    localparam int DATA_W = 32;
    localparam int DUP_N  = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush_i = 1'b0;
    logic                    in_valid_i = 1'b0;
    logic                    in_ready_o;
    logic [PC_W-1:0]         in_pc_i = '0;
    logic [CTRL_W-1:0]       in_ctrl_i = '0;
    logic [DATA_W-1:0]       in_data_i = '0;
    logic                    out_valid_o;
    logic                    out_ready_i = 1'b0;
    logic [PC_W-1:0]         out_pc_o;
    logic [CTRL_W-1:0]       out_ctrl_o;
    logic [DUP_N*DATA_W-1:0] out_data_o;
    logic [1:0]              occ_o;

    pipe_skid_stage #(
        .PC_W   (PC_W),
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .DUP_N  (DUP_N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_pc_i     (in_pc_i),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pc_o    (out_pc_o),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .occ_o       (occ_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t m_exp;
    int    n_checks = 0;
    int    n_fail   = 0;
    time   t0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the beat until accepted; expected entry is queued on the accepting edge
    task automatic send(input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                        input logic [DATA_W-1:0] data);
        bit ok;
        ok = 1'b0;
        in_valid_i = 1'b1;
        in_pc_i    = pc;
        in_ctrl_i  = ctrl;
        in_data_i  = data;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready_o && !flush_i;
            @(posedge clk);
        end
        if (ok) exp_q.push_back({pc, ctrl, data});
        else check("send_timeout", 96'd0, 96'd1);
        #1;
        in_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 96'd1, 96'd0);
            end else begin
                m_exp = exp_q.pop_front();
                check("mon_pc", 96'(out_pc_o), 96'(m_exp.pc));
                check("mon_ctrl", 96'(out_ctrl_o), 96'(m_exp.ctrl));
                for (int k = 0; k < DUP_N; k++)
                    check("mon_data", 96'(out_data_o[k*DATA_W +: DATA_W]), 96'(m_exp.data));
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a beat presented
        in_valid_i = 1'b1;
        in_pc_i    = 32'h100;
        in_ctrl_i  = 16'h00FF;
        in_data_i  = 32'h1234;
        tick(3);
        check("rst_valid", 96'(out_valid_o), 96'd0);
        check("rst_pc", 96'(out_pc_o), 96'd0);
        check("rst_ctrl", 96'(out_ctrl_o), 96'd0);
        check("rst_data", 96'(out_data_o), 96'd0);
        check("rst_occ", 96'(occ_o), 96'd0);
        in_valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_ready", 96'(in_ready_o), 96'd1);

        // Streaming at full rate
        out_ready_i = 1'b1;
        send(32'h0, 16'h0011, 32'hA0);
        check("lat_valid", 96'(out_valid_o), 96'd1);
        check("lat_pc", 96'(out_pc_o), 96'd0);
        t0 = $time;
        send(32'h4, 16'h0012, 32'hA1);
        send(32'h8, 16'h0013, 32'hA2);
        send(32'hC, 16'h0014, 32'hA3);
        check("thru_time", 96'($time - t0), 96'd30);
        check("stream_occ", 96'(occ_o), 96'd1);
        tick(2);
        check("bubble_valid", 96'(out_valid_o), 96'd0);
        check("bubble_ctrl", 96'(out_ctrl_o), 96'd0);
        check("bubble_pc_hold", 96'(out_pc_o), 96'hC);
        check("stream_drained", 96'(exp_q.size()), 96'd0);

        // Back-pressure
        out_ready_i = 1'b0;
`ifdef PIPE_SKID_EN
        send(32'h10, 16'h0021, 32'hB0);
        send(32'h14, 16'h0022, 32'hB1);
        check("stall_occ", 96'(occ_o), 96'd2);
        check("stall_ready", 96'(in_ready_o), 96'd0);
        check("stall_pc", 96'(out_pc_o), 96'h10);
        out_ready_i = 1'b1;
        #1;
        check("ready_registered", 96'(in_ready_o), 96'd0);
        tick(3);
        check("release_occ", 96'(occ_o), 96'd0);
`else
        send(32'h10, 16'h0021, 32'hB0);
        check("stall_occ", 96'(occ_o), 96'd1);
        check("stall_ready", 96'(in_ready_o), 96'd0);
        out_ready_i = 1'b1;
        #1;
        check("comb_ready_hi", 96'(in_ready_o), 96'd1);
        out_ready_i = 1'b0;
        #1;
        check("comb_ready_lo", 96'(in_ready_o), 96'd0);
        out_ready_i = 1'b1;
        tick(2);
        send(32'h14, 16'h0022, 32'hB1);
        tick(2);
`endif
        check("stall_drained", 96'(exp_q.size()), 96'd0);

        // Flush with a beat presented in the flush cycle
        out_ready_i = 1'b0;
        send(32'h20, 16'h0031, 32'hC0);
`ifdef PIPE_SKID_EN
        send(32'h24, 16'h0032, 32'hC1);
        check("preflush_occ", 96'(occ_o), 96'd2);
`else
        check("preflush_occ", 96'(occ_o), 96'd1);
`endif
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_pc_i    = 32'h30;
        in_ctrl_i  = 16'h0033;
        in_data_i  = 32'hC3;
        tick(1);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        exp_q.delete();
        check("flush_valid", 96'(out_valid_o), 96'd0);
        check("flush_ctrl", 96'(out_ctrl_o), 96'd0);
        check("flush_occ", 96'(occ_o), 96'd0);
        check("flush_ready", 96'(in_ready_o), 96'd1);
        out_ready_i = 1'b1;
        tick(3);
        check("flush_discard", 96'(out_valid_o), 96'd0);

        // Replicated data copies
        send(32'h50, 16'h0055, 32'hDEADBEEF);
        for (int k = 0; k < DUP_N; k++)
            check("dup_copy", 96'(out_data_o[k*DATA_W +: DATA_W]), 96'hDEADBEEF);
        check("dup_ctrl", 96'(out_ctrl_o), 96'h55);
        tick(2);

        // Asynchronous reset while holding beats
        out_ready_i = 1'b0;
        send(32'h60, 16'h0061, 32'hE0);
`ifdef PIPE_SKID_EN
        send(32'h64, 16'h0062, 32'hE1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 96'(out_valid_o), 96'd0);
        check("arst_occ", 96'(occ_o), 96'd0);
        check("arst_pc", 96'(out_pc_o), 96'd0);
        check("arst_data", 96'(out_data_o), 96'd0);
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        tick(2);
        check("arst_after", 96'(out_valid_o), 96'd0);
        check("final_queue", 96'(exp_q.size()), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
